// File: rtl/sync_fifo_prog_if.sv
// Producer/consumer bundle for sync_fifo_prog.
// Optional macro SYNC_FIFO_PEAK_EN adds the peak_count signal.
interface sync_fifo_prog_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic [CW-1:0]         af_thresh;
  logic [CW-1:0]         ae_thresh;
  logic                  clr_err;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;
  logic [CW-1:0]         count;
`ifdef SYNC_FIFO_PEAK_EN
  logic [CW-1:0]         peak_count;
`endif

  // Upstream/downstream agent side.
  modport master (
    output wr_en, wr_data, rd_en, af_thresh, ae_thresh, clr_err,
`ifdef SYNC_FIFO_PEAK_EN
    input  peak_count,
`endif
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           overflow, underflow, count
  );

  // FIFO side.
  modport slave (
    input  wr_en, wr_data, rd_en, af_thresh, ae_thresh, clr_err,
`ifdef SYNC_FIFO_PEAK_EN
    output peak_count,
`endif
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           overflow, underflow, count
  );
endinterface

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost flags, selectable
// registered / first-word-fall-through read, and sticky error flags.
// Optional macro SYNC_FIFO_PEAK_EN adds a peak occupancy tracker.
module sync_fifo_prog #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int FWFT       = 0,
  parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input logic             clk,
  input logic             rst,
  sync_fifo_prog_if.slave fifo
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic                  is_full, is_empty, wr_ok, rd_ok;
  logic                  ovf, unf;

  assign is_full  = (cnt == CW'(FIFO_DEPTH));
  assign is_empty = (cnt == '0);
  // A full FIFO still takes a write when the same cycle pops a word.
  assign rd_ok    = fifo.rd_en && !is_empty;
  assign wr_ok    = fifo.wr_en && (!is_full || rd_ok);

  // Occupancy after this edge; also feeds the peak tracker.
  always_comb begin
    cnt_nxt = cnt;
    if (wr_ok && !rd_ok)      cnt_nxt = cnt + CW'(1);
    else if (rd_ok && !wr_ok) cnt_nxt = cnt - CW'(1);
  end

  // Storage write; contents are don't-care until a pointer covers them.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= fifo.wr_data;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt_nxt;
    end
  end

  // Sticky errors; clear wins over a same-cycle set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (fifo.clr_err) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (fifo.wr_en && !wr_ok) ovf <= 1'b1;
      if (fifo.rd_en && !rd_ok) unf <= 1'b1;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is always presented; rd_en just advances it.
      assign fifo.rd_data  = mem[rd_ptr];
      assign fifo.rd_valid = !is_empty;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] rd_q;
      logic                  rv_q;
      // Registered pop: data and valid land on the accepting edge.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_q <= '0;
          rv_q <= 1'b0;
        end else begin
          rv_q <= rd_ok;
          if (rd_ok) rd_q <= mem[rd_ptr];
        end
      end
      assign fifo.rd_data  = rd_q;
      assign fifo.rd_valid = rv_q;
    end
  endgenerate

`ifdef SYNC_FIFO_PEAK_EN
  logic [CW-1:0] peak;
  // High-water mark; clr_err restarts it from the current occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                peak <= '0;
    else if (fifo.clr_err)  peak <= cnt_nxt;
    else if (cnt_nxt > peak) peak <= cnt_nxt;
  end
  assign fifo.peak_count = peak;
`endif

  assign fifo.full         = is_full;
  assign fifo.empty        = is_empty;
  assign fifo.almost_full  = (cnt >= fifo.af_thresh);
  assign fifo.almost_empty = (cnt <= fifo.ae_thresh);
  assign fifo.overflow     = ovf;
  assign fifo.underflow    = unf;
  assign fifo.count        = cnt;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: a registered-read and a FWFT instance share
// one stimulus stream and are checked against a queue-based model.
module tb_sync_fifo_prog;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int CW = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic          wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [CW-1:0] af_thresh = '0, ae_thresh = '0;

  always #5 clk = ~clk;

  sync_fifo_prog_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) if0 ();
  sync_fifo_prog_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) if1 ();

  assign if0.wr_en = wr_en;     assign if1.wr_en = wr_en;
  assign if0.wr_data = wr_data; assign if1.wr_data = wr_data;
  assign if0.rd_en = rd_en;     assign if1.rd_en = rd_en;
  assign if0.clr_err = clr_err; assign if1.clr_err = clr_err;
  assign if0.af_thresh = af_thresh; assign if1.af_thresh = af_thresh;
  assign if0.ae_thresh = ae_thresh; assign if1.ae_thresh = ae_thresh;

  sync_fifo_prog #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .fifo(if0));
  sync_fifo_prog #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .fifo(if1));

  // Reference model state.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd;
  bit            m_rv, m_ovf, m_unf;
  int            m_peak;
  int            cmp = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rd = '0; m_rv = 0; m_ovf = 0; m_unf = 0; m_peak = 0;
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("d0.count", 32'(if0.count), 32'(n));
    chk("d1.count", 32'(if1.count), 32'(n));
    chk("d0.full", 32'(if0.full), 32'(n == DEPTH));
    chk("d1.full", 32'(if1.full), 32'(n == DEPTH));
    chk("d0.empty", 32'(if0.empty), 32'(n == 0));
    chk("d1.empty", 32'(if1.empty), 32'(n == 0));
    chk("d0.almost_full", 32'(if0.almost_full), 32'(n >= int'(af_thresh)));
    chk("d1.almost_full", 32'(if1.almost_full), 32'(n >= int'(af_thresh)));
    chk("d0.almost_empty", 32'(if0.almost_empty), 32'(n <= int'(ae_thresh)));
    chk("d1.almost_empty", 32'(if1.almost_empty), 32'(n <= int'(ae_thresh)));
    chk("d0.overflow", 32'(if0.overflow), 32'(m_ovf));
    chk("d1.overflow", 32'(if1.overflow), 32'(m_ovf));
    chk("d0.underflow", 32'(if0.underflow), 32'(m_unf));
    chk("d1.underflow", 32'(if1.underflow), 32'(m_unf));
    chk("d0.rd_valid", 32'(if0.rd_valid), 32'(m_rv));
    chk("d0.rd_data", 32'(if0.rd_data), 32'(m_rd));
    chk("d1.rd_valid", 32'(if1.rd_valid), 32'(n != 0));
    if (n != 0) chk("d1.rd_data", 32'(if1.rd_data), 32'(q[0]));
`ifdef SYNC_FIFO_PEAK_EN
    chk("d0.peak_count", 32'(if0.peak_count), 32'(m_peak));
    chk("d1.peak_count", 32'(if1.peak_count), 32'(m_peak));
`endif
  endtask

  // One clock of stimulus; the model reacts to the same pre-edge state.
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    bit rok, wok;
    @(negedge clk);
    wr_en = w; wr_data = d; rd_en = r; clr_err = c;
    rok = r && (q.size() != 0);
    wok = w && ((q.size() != DEPTH) || rok);
    @(posedge clk);
    if (rok) begin m_rd = q.pop_front(); m_rv = 1; end
    else m_rv = 0;
    if (wok) q.push_back(d);
    if (c) begin
      m_ovf = 0; m_unf = 0;
      m_peak = q.size();
    end else begin
      if (w && !wok) m_ovf = 1;
      if (r && !rok) m_unf = 1;
      if (q.size() > m_peak) m_peak = q.size();
    end
    #1;
    check_all();
  endtask

  task automatic idle();
    step(0, '0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state, with af_thresh=0 so almost_full must read 1.
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    af_thresh = CW'(12);
    ae_thresh = CW'(3);
    #1;
    check_all();

    // Known bytes in, first five out in order.
    for (int i = 1; i <= 10; i++) step(1, DW'(i), 0, 0);
    for (int i = 0; i < 5; i++) step(0, '0, 1, 0);
    idle();
    for (int i = 0; i < DEPTH && q.size() != 0; i++) step(0, '0, 1, 0);

    // Fill plus one dropped write, then clear the error.
    for (int i = 0; i < DEPTH + 1; i++) step(1, DW'($urandom), 0, 0);
    step(0, '0, 0, 1);

    // Simultaneous read/write while full.
    for (int i = 0; i < 3; i++) step(1, DW'($urandom), 1, 0);
    for (int i = 0; i < DEPTH && q.size() != 0; i++) step(0, '0, 1, 0);

    // Reads against an empty FIFO, with and without a write.
    step(0, '0, 1, 0);
    step(1, DW'($urandom), 1, 0);
    step(0, '0, 1, 0);
    step(0, '0, 0, 1);

    // Threshold sweep with a live af_thresh change at count 10.
    for (int i = 0; i < 10; i++) step(1, DW'($urandom), 0, 0);
    @(negedge clk);
    wr_en = 0; rd_en = 0;
    af_thresh = CW'(8);
    #1;
    chk("d0.af_live", 32'(if0.almost_full), 32'(1));
    chk("d1.af_live", 32'(if1.almost_full), 32'(1));
    af_thresh = CW'(12);
    #1;
    chk("d0.af_restore", 32'(if0.almost_full), 32'(0));
    for (int i = 0; i < 6; i++) step(1, DW'($urandom), 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, '0, 1, 0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        af_thresh = CW'($urandom_range(0, DEPTH));
        ae_thresh = CW'($urandom_range(0, DEPTH));
      end
      step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
           $urandom_range(0, 15) == 0);
    end

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 5; i++) step(1, DW'($urandom), 0, 0);
    @(negedge clk);
    wr_en = 1; wr_data = DW'($urandom);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    wr_en = 0;
    rst = 1'b0;
    step(1, DW'($urandom), 0, 0);
    step(0, '0, 1, 0);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Parametrised synchronous FIFO, successor to the fixed-flag FIFO.
- Depth and width are generic.
- almost_full / almost_empty thresholds are programmable at run time.
- Read mode is selectable: registered-read or first-word-fall-through (FWFT).
- Overflow/underflow errors are sticky until cleared.
- Sits between producer/consumer stages in a single clock domain.

Parameters:
DATA_WIDTH, 8, width of wr_data/rd_data in bits.
FIFO_DEPTH, 16, number of entries; power of two, >= 4.
FWFT, 0, 0 = registered read (data one cycle after rd_en), 1 = first-word-fall-through.
CW, $clog2(FIFO_DEPTH)+1, width of count and threshold ports (derived, do not override).

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  asynchronous, active-high reset.
wr_en  in  1  write request.
wr_data  in  DATA_WIDTH  write data.
rd_en  in  1  read/pop request.
rd_data  out  DATA_WIDTH  read data.
rd_valid  out  1  rd_data holds a valid popped word (registered mode); equals !empty in FWFT.
af_thresh  in  CW  almost_full threshold.
ae_thresh  in  CW  almost_empty threshold.
clr_err  in  1  clears overflow/underflow.
full  out  1  count == FIFO_DEPTH.
empty  out  1  count == 0.
almost_full  out  1  count >= af_thresh.
almost_empty  out  1  count <= ae_thresh.
overflow  out  1  sticky: a write was dropped.
underflow  out  1  sticky: a read was rejected.
count  out  CW  stored entries.

Behaviour:
- Reset (async assert, sync release):
  - Pointers, count, rd_data, rd_valid, overflow and underflow all go to 0.
  - empty=1, full=0.
  - almost_empty=1 if ae_thresh>=0 (always true); almost_full=(af_thresh==0).
  - Reset mid-transfer discards all contents.
- Storage and pointers:
  - Storage is a DATA_WIDTH x FIFO_DEPTH register array.
  - wr_ptr and rd_ptr are $clog2(FIFO_DEPTH) bits and wrap naturally from FIFO_DEPTH-1 to 0.
  - count is a separate CW-bit counter.
- Acceptance, evaluated on pre-edge state:
  - wr_ok = wr_en && (!full || rd_ok).
  - rd_ok = rd_en && !empty.
- Count update: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
- Full with simultaneous rd_en and wr_en: both accepted; count stays FIFO_DEPTH.
- Empty with simultaneous rd_en and wr_en: write accepted, read rejected, underflow set; count becomes 1.
- Errors:
  - overflow sets on wr_en && !wr_ok.
  - underflow sets on rd_en && !rd_ok.
  - clr_err clears both on the next edge. Clear has priority over a same-cycle set.
- FWFT=0 (registered read):
  - On rd_ok, rd_data <= mem[rd_ptr] and rd_valid <= 1 at the same edge; otherwise rd_valid <= 0.
  - rd_data holds its last value when not reading.
  - Latency: rd_en accepted at edge N gives data valid after edge N.
- FWFT=1 (first-word-fall-through):
  - rd_data = mem[rd_ptr] combinationally; rd_valid = !empty.
  - rd_en pops the head.
  - A word written into an empty FIFO appears on rd_data one cycle after its write edge.
- Flags:
  - full, empty, almost_full and almost_empty are combinational from count and the thresholds.
  - Threshold changes take effect the same cycle.
- count never exceeds FIFO_DEPTH and never underflows below 0.

Optional Feature:
SYNC_FIFO_PEAK_EN
- Defined:
  - Adds output peak_count [CW] holding the maximum count seen since reset or clr_err.
  - Updated each edge as max(peak_count, next count).
  - Reset value 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, then write 10 bytes 0x01..0x0A, then read 5 -> count=5; rd_data sequence 0x01..0x05 with one-cycle latency (FWFT=0); empty=0, full=0.
2. Write 16 words into an empty FIFO, then a 17th write -> full=1, count=16, overflow=1; the 17th word is never read back. Then clr_err -> overflow=0.
3. With the FIFO full, assert wr_en and rd_en together for 3 cycles -> count stays 16; no overflow; output order is preserved across pointer wrap.
4. Assert rd_en while empty, with and without wr_en -> underflow=1, rd_valid=0. With wr_en, count=1 and that word is read back next.
5. Set af_thresh=12 and ae_thresh=3, then fill 0->16 and drain -> almost_full asserts at count 12 and almost_empty deasserts at count 4, both on the same cycle count changes. Changing af_thresh to 8 at count 10 asserts almost_full immediately.
6. FWFT=1 build: write 0xA5 into an empty FIFO -> rd_data=0xA5 and rd_valid=1 on the next cycle without rd_en; pop -> empty=1. Assert rst mid-burst -> count=0 and flags return to reset values asynchronously. With SYNC_FIFO_PEAK_EN defined, peak_count=16 after test 2.
